// File: rtl/alu_seq.sv
// Sequential ALU: one-edge result for most ops, WIDTH-iteration shift-add multiply for op 14.
// Result is held in DONE until out_ready; requests are refused (in_ready=0) outside IDLE.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       inst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ans,
   output logic             carry,
   output logic             zero,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH:0] ONE  = (WIDTH + 1)'(1);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t               state;
   logic [WIDTH:0]       res;
   logic [2*WIDTH-1:0]   prod;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   prod_nxt;
   logic [WIDTH-1:0]     mplier;
   logic [CW-1:0]        cnt;

   // res is {carry, ans}; the default keeps the old result so NOPs need no special case
   always_comb begin
      res = {carry, ans};
      case (inst)
         4'd0:  res = {1'b0, b};
         4'd1:  res = {1'b0, a};
         4'd2:  res = {1'b0, a} + {1'b0, b};
         4'd3:  res = {1'b0, a} - {1'b0, b};
         4'd4:  res = {1'b0, a & b};
         4'd5:  res = {1'b0, b} + ONE;
         4'd6:  res = {1'b0, b} - ONE;
         4'd7:  res = {1'b0, a ^ b};
         4'd9:  res = '0;
         4'd10: res = {1'b0, a | b};
         4'd11: res = {1'b0, b[WIDTH/2-1:0], b[WIDTH-1:WIDTH/2]};
         4'd12: res = {b, 1'b0};
         4'd13: res = {b[0], 1'b0, b[WIDTH-1:1]};
         default: res = {carry, ans};
      endcase
   end

   assign prod_nxt = prod + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ans       <= '0;
         carry     <= 1'b0;
         zero      <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b0;
         prod      <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  if (inst == 4'd14) begin
                     state  <= MUL;
                     busy   <= 1'b1;
                     prod   <= '0;
                     mcand  <= {{WIDTH{1'b0}}, a};
                     mplier <= b;
                     cnt    <= '0;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     ans       <= res[WIDTH-1:0];
                     carry     <= res[WIDTH];
                     zero      <= (res[WIDTH-1:0] == '0);
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end
            MUL: begin
               prod   <= prod_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  ans       <= prod_nxt[WIDTH-1:0];
                  carry     <= |prod_nxt[2*WIDTH-1:WIDTH];
                  zero      <= (prod_nxt[WIDTH-1:0] == '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded bench for alu_seq: directed corner cases plus random ops against an arithmetic model.
module tb_alu_seq;
   localparam int W = 8;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   inst = 4'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] ans;
   logic         carry;
   logic         zero;
   logic         busy;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .ans(ans), .carry(carry), .zero(zero), .busy(busy)
   );

   typedef struct {int ans; int carry;} exp_t;
   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   m_ans = 0;
   int   m_carry = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // reference model: plain integer arithmetic on the opcode table
   function automatic void model(input int op, input int ai, input int bi);
      int r, c, p;
      r = m_ans;
      c = m_carry;
      case (op)
         0:  begin r = bi; c = 0; end
         1:  begin r = ai; c = 0; end
         2:  begin r = (ai + bi) & MASK; c = ((ai + bi) > MASK) ? 1 : 0; end
         3:  begin r = (ai - bi) & MASK; c = (ai < bi) ? 1 : 0; end
         4:  begin r = ai & bi; c = 0; end
         5:  begin r = (bi + 1) & MASK; c = ((bi + 1) > MASK) ? 1 : 0; end
         6:  begin r = (bi - 1) & MASK; c = (bi == 0) ? 1 : 0; end
         7:  begin r = ai ^ bi; c = 0; end
         9:  begin r = 0; c = 0; end
         10: begin r = ai | bi; c = 0; end
         11: begin r = ((bi % 16) * 16) + (bi / 16); c = 0; end
         12: begin r = (bi * 2) & MASK; c = (bi >= 128) ? 1 : 0; end
         13: begin r = bi / 2; c = bi % 2; end
         14: begin p = ai * bi; r = p % 256; c = (p / 256 != 0) ? 1 : 0; end
         default: ;
      endcase
      m_ans = r;
      m_carry = c;
      sbq.push_back('{r, c});
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (reset && out_valid === 1'b1 && out_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=0x%0h required=none", ans);
         end else begin
            e = sbq.pop_front();
            chk("mon_ans", 32'(ans), 32'(e.ans));
            chk("mon_carry", 32'(carry), 32'(e.carry));
            chk("mon_zero", 32'(zero), (e.ans == 0) ? 32'd1 : 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int op, input int ai, input int bi);
      int n = 0;
      while (in_ready !== 1'b1 && n < 100) begin step(); n++; end
      if (in_ready !== 1'b1) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      inst = 4'(op);
      a = W'(ai);
      b = W'(bi);
      model(op, ai, bi);
      step();
      in_valid = 1'b0;
   endtask

   task automatic complete(input int stall);
      int n = 0;
      if (stall > 0) out_ready = 1'b0;
      while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
      if (out_valid !== 1'b1) chk("out_valid_timeout", 32'(out_valid), 32'd1);
      repeat (stall) step();
      out_ready = 1'b1;
      step();
   endtask

   initial begin
      int bc, n, op, stall;
      #2 reset = 1'b0;
      #20;
      chk("rst_ans", 32'(ans), 32'd0);
      chk("rst_carry", 32'(carry), 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      step();
      reset = 1'b1;
      chk("in_ready_before_edge", 32'(in_ready), 32'd0);
      step();
      chk("in_ready_first_edge", 32'(in_ready), 32'd1);

      issue(2, 8'hFF, 8'h01);
      chk("add_latency_valid", 32'(out_valid), 32'd1);
      complete(0);
      issue(3, 8'h05, 8'h07);
      complete(0);
      issue(11, 8'h00, 8'hA5);
      chk("swap_ans", 32'(ans), 32'h5A);
      complete(0);

      issue(14, 8'h10, 8'h20);
      in_valid = 1'b1; inst = 4'd0; a = 8'h55; b = 8'h66;
      bc = 0; n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         chk("mul_in_ready_low", 32'(in_ready), 32'd0);
         if (busy === 1'b1) bc++;
         step();
         n++;
      end
      in_valid = 1'b0;
      chk("mul_busy_cycles", 32'(bc), 32'd8);
      chk("mul_busy_done", 32'(busy), 32'd0);
      complete(0);
      step();
      chk("mul_ignored_req", 32'(out_valid), 32'd0);

      out_ready = 1'b0;
      issue(2, 8'h12, 8'h34);
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_ans", 32'(ans), 32'h46);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("release_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);

      issue(14, 8'h0F, 8'h0F);
      repeat (3) step();
      #2 reset = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ans", 32'(ans), 32'd0);
      chk("abort_zero", 32'(zero), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      void'(sbq.pop_back());
      m_ans = 0;
      m_carry = 0;
      step();
      step();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
      reset = 1'b1;
      issue(5, 8'h00, 8'h7F);
      chk("inc_ans", 32'(ans), 32'h80);
      chk("inc_carry", 32'(carry), 32'd0);
      complete(0);

      issue(2, 8'h10, 8'h20);
      complete(0);
      issue(8, 8'hAA, 8'hBB);
      chk("nop_valid", 32'(out_valid), 32'd1);
      chk("nop_ans", 32'(ans), 32'h30);
      complete(0);

      for (int k = 0; k < 80; k++) begin
         op = int'($urandom_range(0, 15));
         stall = int'($urandom_range(0, 2));
         issue(op, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
         complete(stall);
      end

      step();
      chk("queue_empty", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
